oled_spi_rx: RTL and testbench
==============================

// Module: oled_spi_rx
// PURPOSE
//  Receive side of the write-only OLED serial link (SCLK/SDIN/DC/RES) driven by the OLED controller.
//  Oversamples the link on GCLK, rebuilds MSB-first bytes tagged command/data, queues them in a FIFO
//  and presents them on a valid/ready stream. Used in sandbox loopback via JA/JB pins and as a bench monitor.
// PARAMETERS
//  FIFO_DEPTH   16     entries of {DC,byte}; power of two, >=2
//  IDLE_CYCLES  1024   GCLK cycles with no SCLK rising edge that end a transfer; >=8
// PORTS
//  GCLK        in   1   system clock; only clock
//  RST         in   1   synchronous, active-high reset
//  SCLK_IN     in   1   async serial clock from link; high/low phase each >=3 GCLK cycles
//  SDIN_IN     in   1   async serial data, valid at SCLK rising edge
//  DC_IN       in   1   async; 0=command, 1=data; stable across the byte
//  RES_IN      in   1   async, active-low OLED reset
//  RX_DATA     out  8   head-of-FIFO byte
//  RX_DC       out  1   DC tag of RX_DATA
//  RX_VALID    out  1   head entry valid
//  RX_READY    in   1   consumer accepts when RX_VALID&RX_READY
//  FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1   entries held
//  OVERFLOW    out  1   sticky: byte dropped because FIFO full
//  FRAME_ERR   out  1   1-cycle pulse: partial byte discarded
//  BYTE_COUNT  out  16  bytes accepted into FIFO, wraps 0xFFFF->0
//  CLR_FLAGS   in   1   clears OVERFLOW when high
// BEHAVIOUR
//  Reset (RST=1 at GCLK edge): all outputs 0, FIFO empty, bit count 0, idle timer 0, sync flops 0.
//  Input path: SCLK_IN, SDIN_IN, DC_IN, RES_IN each 2-flop synchronized; SCLK 3rd flop for edge detect.
//   rise = sclk_s2 & ~sclk_s3; SDIN and DC sampled from s2 stage in the rise cycle.
//  Shifter: on rise, sh <= {sh[6:0],sdin}; bit_cnt++. On 8th rise: byte={sh[6:0],sdin}, tag=DC sample,
//   bit_cnt<=0, push request raised for next cycle.
//  Latency: 8th SCLK rising edge at pin -> RX_VALID high exactly 4 GCLK cycles later (FIFO empty case).
//  FSM: IDLE -(rise)-> SHIFT -(8th rise)-> PUSH -> SHIFT. SHIFT -(idle timer==IDLE_CYCLES-1)-> IDLE.
//   Idle timer clears on every rise; counts in SHIFT/PUSH only.
//   Timeout with bit_cnt 1..7: discard bits, FRAME_ERR pulse 1 cycle, -> IDLE. bit_cnt 0: no pulse.
//   RES sync low: bit_cnt<=0, -> IDLE, FRAME_ERR if bit_cnt!=0; FIFO contents kept.
//  FIFO: first-word-fall-through; RX_DATA/RX_DC/RX_VALID registered, no same-cycle push->pop bypass.
//   Pop when RX_VALID&RX_READY; RX_DATA unchanged while RX_VALID&~RX_READY.
//   Push with FIFO full and no pop: byte dropped, OVERFLOW<=1, BYTE_COUNT unchanged.
//   Push and pop same cycle when full: both happen, no overflow, level unchanged.
//   Push and pop same cycle otherwise: level unchanged.
//   Pointers wrap modulo FIFO_DEPTH. FIFO_LEVEL exact, 0..FIFO_DEPTH.
//  OVERFLOW: set has priority over CLR_FLAGS in same cycle.
//  RST mid-byte: partial byte and FIFO discarded, no FRAME_ERR.
// TESTING
//  1 Send 0xA5 DC=0, RX_READY=1 -> one beat RX_DATA=A5, RX_DC=0, RX_VALID 4 cycles after 8th rise; BYTE_COUNT=1.
//  2 Send 20 bytes 0x00..0x13 DC=1, RX_READY=0 -> FIFO_LEVEL=16, OVERFLOW=1, BYTE_COUNT=16; drain gives 0x00..0x0F in order.
//  3 Send 5 bits then hold SCLK IDLE_CYCLES -> FRAME_ERR one pulse; next byte 0x3C received intact.
//  4 Full FIFO, RX_READY=1 aligned with push of 0x7E -> OVERFLOW stays 0, level stays 16, 0x7E last out.
//  5 RES_IN low after 3 bits -> FRAME_ERR pulse; next byte 0xAF DC=0 received correctly.
//  6 RST after 4 bits with 3 queued -> RX_VALID=0, FIFO_LEVEL=0, BYTE_COUNT=0; next byte 0x81 ok.

Source files
------------

// File: rtl/oled_spi_rx.sv
// Receive side of the OLED serial link: oversampled on GCLK, bytes rebuilt MSB-first,
// tagged with DC and queued in a first-word-fall-through FIFO behind a valid/ready stream.
module oled_spi_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic                          GCLK,
    input  logic                          RST,
    input  logic                          SCLK_IN,
    input  logic                          SDIN_IN,
    input  logic                          DC_IN,
    input  logic                          RES_IN,
    output logic [7:0]                    RX_DATA,
    output logic                          RX_DC,
    output logic                          RX_VALID,
    input  logic                          RX_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW,
    output logic                          FRAME_ERR,
    output logic [15:0]                   BYTE_COUNT,
    input  logic                          CLR_FLAGS
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(IDLE_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    state_t        state;
    state_t        next_state;
    logic          timeout;
    logic          abort;

    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          sdin_s1, sdin_s2;
    logic          dc_s1, dc_s2;
    logic          res_s1, res_s2;
    logic          rise;

    logic [6:0]    sh;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_reg;
    logic          tag_reg;
    logic [TW-1:0] idle_timer;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   remain;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;

    always_ff @(posedge GCLK) begin
        if (RST) begin
            {sclk_s1, sclk_s2, sclk_s3} <= '0;
            {sdin_s1, sdin_s2}          <= '0;
            {dc_s1, dc_s2}              <= '0;
            {res_s1, res_s2}            <= '0;
        end else begin
            sclk_s1 <= SCLK_IN;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            sdin_s1 <= SDIN_IN;
            sdin_s2 <= sdin_s1;
            dc_s1   <= DC_IN;
            dc_s2   <= dc_s1;
            res_s1  <= RES_IN;
            res_s2  <= res_s1;
        end
    end

    assign rise  = sclk_s2 & ~sclk_s3;
    assign abort = ~res_s2;

    always_ff @(posedge GCLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            IDLE:  if (rise) next_state = SHIFT;
            SHIFT: begin
                if (rise && bit_cnt == 3'd7) begin
                    next_state = PUSH;
                end else if (!rise && idle_timer == TW'(IDLE_CYCLES - 1)) begin
                    next_state = IDLE;
                    timeout    = 1'b1;
                end
            end
            PUSH:  next_state = SHIFT;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // A held-low OLED reset or a silent link both abandon any partial byte.
    always_ff @(posedge GCLK) begin
        if (RST) begin
            sh         <= '0;
            bit_cnt    <= '0;
            byte_reg   <= '0;
            tag_reg    <= 1'b0;
            FRAME_ERR  <= 1'b0;
            idle_timer <= '0;
        end else begin
            FRAME_ERR <= 1'b0;
            if (abort || timeout) begin
                bit_cnt   <= '0;
                FRAME_ERR <= (bit_cnt != 3'd0);
            end else if (rise) begin
                sh <= {sh[5:0], sdin_s2};
                if (bit_cnt == 3'd7) begin
                    byte_reg <= {sh, sdin_s2};
                    tag_reg  <= dc_s2;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (state == IDLE || rise) idle_timer <= '0;
            else                       idle_timer <= idle_timer + TW'(1);
        end
    end

    assign push   = (state == PUSH);
    assign pop    = RX_VALID & RX_READY;
    assign full   = (count == (AW + 1)'(FIFO_DEPTH));
    assign wr_en  = push & (~full | pop);
    assign remain = count - (AW + 1)'(pop);

    always_ff @(posedge GCLK) begin
        if (wr_en) mem[wr_ptr] <= {tag_reg, byte_reg};
    end

    // The head register only sees entries written on earlier cycles, so a fresh push
    // becomes visible one cycle after it lands.
    always_ff @(posedge GCLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            RX_VALID   <= 1'b0;
            RX_DATA    <= '0;
            RX_DC      <= 1'b0;
            OVERFLOW   <= 1'b0;
            BYTE_COUNT <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + AW'(1);
                BYTE_COUNT <= BYTE_COUNT + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            RX_VALID <= (remain != '0);
            if (remain != '0) {RX_DC, RX_DATA} <= mem[rd_ptr + AW'(pop)];
            if (push && !wr_en) OVERFLOW <= 1'b1;
            else if (CLR_FLAGS) OVERFLOW <= 1'b0;
        end
    end

    assign FIFO_LEVEL = count;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: bytes are bit-banged onto the link, expected beats
// queued at send time and checked by a monitor whenever the stream hands one over.
module tb_oled_spi_rx;

    localparam int DEPTH = 16;
    localparam int IDLE  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, sdin, dc, res_n;
    logic [7:0]  rx_data;
    logic        rx_dc, rx_valid, rx_ready;
    logic [4:0]  fifo_level;
    logic        overflow, frame_err;
    logic [15:0] byte_count;
    logic        clr_flags;

    oled_spi_rx #(.FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
        .GCLK(clk), .RST(rst), .SCLK_IN(sclk), .SDIN_IN(sdin), .DC_IN(dc), .RES_IN(res_n),
        .RX_DATA(rx_data), .RX_DC(rx_dc), .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .FIFO_LEVEL(fifo_level), .OVERFLOW(overflow), .FRAME_ERR(frame_err),
        .BYTE_COUNT(byte_count), .CLR_FLAGS(clr_flags)
    );

    always #5 clk = ~clk;

    int         asserts = 0;
    int         failures = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         valid_cyc = 0;
    int         fe_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [8:0] last_pop = '0;
    logic [8:0] exp_q[$];
    int         bc_model = 0;
    logic       ov_model = 1'b0;
    logic       rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        asserts++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every accepted beat is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (rx_valid && !prev_valid) valid_cyc = cyc;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", {23'd0, rx_dc, rx_data}, 32'h1ff);
                end else begin
                    check_output("beat", {23'd0, rx_dc, rx_data}, {23'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                last_pop = {rx_dc, rx_data};
            end
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bits(input int n, input logic [7:0] pattern);
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            sdin = pattern[i];
            tick(4);
            sclk = 1'b1;
            tick(4);
        end
    endtask

    // Sends one byte; align_pop raises RX_READY for the single cycle in which the byte lands.
    task automatic apply_stimulus(input logic [7:0] b, input logic tag, input logic align_pop);
        logic acc;
        acc = align_pop || (exp_q.size() < DEPTH);
        if (acc) begin
            exp_q.push_back({tag, b});
            bc_model = (bc_model + 1) % 65536;
        end else begin
            ov_model = 1'b1;
        end
        dc = tag;
        for (int i = 7; i >= 0; i--) begin
            sclk = 1'b0;
            sdin = b[i];
            tick(4);
            sclk = 1'b1;
            if (i == 0) rise_cyc = cyc + 1;
            if (i == 0 && align_pop) begin
                tick(3);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end else begin
                tick(4);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (exp_q.size() == 0 && !rx_valid) done = 1;
            else tick(1);
        end
        check_output(name, exp_q.size(), 0);
    endtask

    initial begin
        int fe0;
        rst = 1'b1; sclk = 1'b0; sdin = 1'b0; dc = 1'b0; res_n = 1'b1;
        rx_ready = 1'b0; clr_flags = 1'b0;
        tick(3);
        check_output("reset_valid", rx_valid, 0);
        check_output("reset_level", fifo_level, 0);
        check_output("reset_count", byte_count, 0);
        check_output("reset_overflow", overflow, 0);
        check_output("reset_frame_err", frame_err, 0);
        check_output("reset_data", {rx_dc, rx_data}, 0);
        rst = 1'b0;
        tick(4);

        // Single command byte and its latency
        rx_ready = 1'b1;
        apply_stimulus(8'hA5, 1'b0, 1'b0);
        tick(10);
        check_output("latency", valid_cyc - rise_cyc, 4);
        check_output("t1_count", byte_count, bc_model);
        wait_drain("t1_drain");

        // Overfill with consumer stalled
        rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) apply_stimulus(8'(i), 1'b1, 1'b0);
        tick(8);
        check_output("t2_level", fifo_level, exp_q.size());
        check_output("t2_level_full", fifo_level, DEPTH);
        check_output("t2_overflow", overflow, ov_model);
        check_output("t2_count", byte_count, bc_model);
        check_output("t2_head", {rx_valid, rx_dc, rx_data}, {1'b1, exp_q[0]});
        tick(5);
        check_output("t2_head_hold", {rx_dc, rx_data}, exp_q[0]);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        ov_model = 1'b0;
        check_output("t2_clear", overflow, ov_model);
        rx_ready = 1'b1;
        wait_drain("t2_drain");
        check_output("t2_level_empty", fifo_level, 0);
        check_output("no_spurious_fe", fe_cnt, 0);

        // Partial byte then link silence
        send_bits(5, 8'hFF);
        fe0 = fe_cnt;
        tick(IDLE + 20);
        check_output("t3_frame_err", fe_cnt - fe0, 1);
        apply_stimulus(8'h3C, 1'b1, 1'b0);
        tick(10);
        wait_drain("t3_drain");

        // Full FIFO with push and pop in the same cycle
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) apply_stimulus(8'h60 + 8'(i), 1'b1, 1'b0);
        tick(8);
        check_output("t4_full", fifo_level, DEPTH);
        apply_stimulus(8'h7E, 1'b0, 1'b1);
        tick(8);
        check_output("t4_overflow", overflow, 0);
        check_output("t4_level", fifo_level, DEPTH);
        check_output("t4_count", byte_count, bc_model);
        rx_ready = 1'b1;
        wait_drain("t4_drain");
        check_output("t4_last", last_pop, 9'h07E);

        // OLED reset in the middle of a byte
        send_bits(3, 8'hA0);
        fe0 = fe_cnt;
        res_n = 1'b0;
        tick(5);
        res_n = 1'b1;
        tick(5);
        check_output("t5_frame_err", fe_cnt - fe0, 1);
        apply_stimulus(8'hAF, 1'b0, 1'b0);
        tick(10);
        wait_drain("t5_drain");

        // System reset with bytes queued and a partial byte
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(8'($urandom), 1'b1, 1'b0);
        send_bits(4, 8'h50);
        fe0 = fe_cnt;
        rst = 1'b1;
        sclk = 1'b0;
        tick(3);
        check_output("t6_valid", rx_valid, 0);
        check_output("t6_level", fifo_level, 0);
        check_output("t6_count", byte_count, 0);
        rst = 1'b0;
        exp_q.delete();
        bc_model = 0;
        ov_model = 1'b0;
        tick(4);
        check_output("t6_no_fe", fe_cnt - fe0, 0);
        rx_ready = 1'b1;
        apply_stimulus(8'h81, 1'b1, 1'b0);
        tick(10);
        wait_drain("t6_drain");
        check_output("t6_count_after", byte_count, bc_model);

        // Random bytes with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            tick($urandom_range(0, 20));
        end
        tick(10);
        rand_ready = 1'b0;
        rx_ready = 1'b1;
        wait_drain("rand_drain");
        check_output("rand_count", byte_count, bc_model);
        check_output("rand_overflow", overflow, ov_model);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
